// File: rtl/accel_frame_fifo.sv
// Accelerometer frame FIFO: assembles SPI byte pairs into axis samples and buffers whole frames.
// Define ACCEL_FIFO_DROP_OLDEST_EN to evict the oldest idle frame on overflow instead of the incoming one.
module accel_frame_fifo #(
  parameter int unsigned NUM_AXES = 3,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_data,
  output logic [1:0]               out_axis,
  output logic                     out_last,
  input  logic [1:0]               latest_sel,
  output logic [15:0]              latest_data,
  output logic [$clog2(DEPTH):0]   frame_count,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [7:0]               drop_count
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [2:0]  LAST_BI = 3'(2 * NUM_AXES - 1);
  localparam logic [1:0]  LAST_WP = 2'(NUM_AXES - 1);
`ifdef ACCEL_FIFO_DROP_OLDEST_EN
  localparam logic DROP_OLDEST = 1'b1;
`else
  localparam logic DROP_OLDEST = 1'b0;
`endif

  logic [2:0]  r_bi;
  logic [7:0]  r_low;
  logic [15:0] r_stage  [4];
  logic [15:0] r_latest [4];
  logic [15:0] r_mem    [DEPTH][NUM_AXES];
  logic [AW:0] r_wptr, r_rptr;
  logic [1:0]  r_wp;
  logic        r_out_valid, r_out_last;
  logic [15:0] r_out_data;
  logic [1:0]  r_out_axis;
  logic        r_ovf;
  logic [7:0]  r_drop;

  logic [2:0]    w_bi;
  logic [1:0]    w_axis;
  logic [15:0]   w_word;
  logic          w_hi, w_commit;
  logic [15:0]   w_frame [NUM_AXES];
  logic          w_accept, w_pop, w_full, w_loss, w_evict, w_wr, w_rd, w_nonempty;
  logic [AW:0]   w_wptr_n, w_rptr_n;
  logic [1:0]    w_wp_n;
  logic [AW-1:0] w_head;
  logic [15:0]   w_head_word;

  always_comb begin
    w_bi     = frame_start ? '0 : r_bi;
    w_axis   = w_bi[2:1];
    w_word   = {byte_data, r_low};
    w_hi     = byte_valid && w_bi[0];
    w_commit = byte_valid && (w_bi == LAST_BI);
    for (int unsigned a = 0; a < NUM_AXES; a++)
      w_frame[2'(a)] = (a == NUM_AXES - 1) ? w_word : r_stage[2'(a)];

    w_accept = r_out_valid && out_ready;
    w_pop    = w_accept && (r_wp == LAST_WP);
    w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    w_loss   = w_commit && w_full && !w_pop;
    // A word accepted this cycle means the head frame is already being read.
    w_evict  = w_loss && DROP_OLDEST && (r_wp == '0) && !w_accept;
    w_wr     = w_commit && (!w_loss || w_evict);
    w_rd     = w_pop || w_evict;
    w_wptr_n = r_wptr + (AW+1)'(w_wr);
    w_rptr_n = r_rptr + (AW+1)'(w_rd);
    w_wp_n   = w_pop ? '0 : (w_accept ? r_wp + 2'd1 : r_wp);

    // Bypass the frame being written when it becomes the new head.
    w_head      = w_rptr_n[AW-1:0];
    w_head_word = (w_wr && (w_head == r_wptr[AW-1:0])) ? w_frame[w_wp_n] : r_mem[w_head][w_wp_n];
    w_nonempty  = (w_wptr_n != w_rptr_n);

    latest_data = (32'(latest_sel) < NUM_AXES) ? r_latest[latest_sel] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bi        <= '0;
      r_low       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_wp        <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_axis  <= '0;
      r_out_last  <= 1'b0;
      r_ovf       <= 1'b0;
      r_drop      <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_stage[2'(i)]  <= '0;
        r_latest[2'(i)] <= '0;
      end
    end else begin
      if (byte_valid) begin
        if (!w_bi[0]) r_low <= byte_data;
        r_bi <= w_commit ? '0 : w_bi + 3'd1;
      end else if (frame_start) begin
        r_bi <= '0;
      end
      if (w_hi) begin
        r_stage[w_axis]  <= w_word;
        r_latest[w_axis] <= w_word;
      end

      r_wptr      <= w_wptr_n;
      r_rptr      <= w_rptr_n;
      r_wp        <= w_wp_n;
      r_out_valid <= w_nonempty;
      r_out_data  <= w_nonempty ? w_head_word : '0;
      r_out_axis  <= w_nonempty ? w_wp_n : '0;
      r_out_last  <= w_nonempty && (w_wp_n == LAST_WP);

      if (ovf_clr) begin
        r_ovf  <= 1'b0;
        r_drop <= '0;
      end else if (w_loss) begin
        r_ovf <= 1'b1;
        if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      for (int unsigned a = 0; a < NUM_AXES; a++)
        r_mem[r_wptr[AW-1:0]][2'(a)] <= w_frame[2'(a)];
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_axis    = r_out_axis;
  assign out_last    = r_out_last;
  assign frame_count = r_wptr - r_rptr;
  assign overflow    = r_ovf;
  assign drop_count  = r_drop;

endmodule

// File: tb/tb_accel_frame_fifo.sv
// Self-checking bench for accel_frame_fifo: queue-based frame model plus directed literal checks.
module tb_accel_frame_fifo;

  localparam int N = 3;
  localparam int D = 16;
`ifdef ACCEL_FIFO_DROP_OLDEST_EN
  localparam bit DROP_OLD = 1'b1;
`else
  localparam bit DROP_OLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, frame_start, byte_valid, out_ready, ovf_clr;
  logic [7:0]  byte_data;
  logic        out_valid, out_last, overflow;
  logic [15:0] out_data, latest_data;
  logic [1:0]  out_axis, latest_sel;
  logic [4:0]  frame_count;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  accel_frame_fifo #(.NUM_AXES(N), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_axis(out_axis), .out_last(out_last),
    .latest_sel(latest_sel), .latest_data(latest_data), .frame_count(frame_count),
    .overflow(overflow), .ovf_clr(ovf_clr), .drop_count(drop_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: frames are whole 64-bit entries in a queue.
  logic [63:0] q[$];
  int          m_bi, m_rd, m_drop, idx;
  logic [7:0]  m_low;
  logic [63:0] m_stage;
  logic [15:0] m_lat [4];
  logic [15:0] wv;
  bit          m_ovf, loss;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_bi = 0; m_rd = 0; m_drop = 0; m_ovf = 0; m_low = '0; m_stage = '0;
      for (int i = 0; i < 4; i++) m_lat[i] = '0;
    end else begin
      loss = 0;
      if (q.size() != 0 && out_ready) begin
        if (m_rd == N - 1) begin
          void'(q.pop_front());
          m_rd = 0;
        end else m_rd++;
      end
      if (byte_valid) begin
        idx = frame_start ? 0 : m_bi;
        if (idx % 2 == 0) m_low = byte_data;
        else begin
          wv = {byte_data, m_low};
          m_lat[idx / 2] = wv;
          m_stage[(idx / 2) * 16 +: 16] = wv;
        end
        if (idx == 2 * N - 1) begin
          if (q.size() < D) q.push_back(m_stage);
          else begin
            loss = 1;
            if (DROP_OLD && m_rd == 0) begin
              void'(q.pop_front());
              q.push_back(m_stage);
            end
          end
          m_bi = 0;
        end else m_bi = idx + 1;
      end else if (frame_start) m_bi = 0;
      if (ovf_clr) begin
        m_ovf = 0; m_drop = 0;
      end else if (loss) begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
    end
  end

  logic [63:0] hf;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 32'(out_valid), 32'(q.size() != 0));
      chk("frame_count", 32'(frame_count), 32'(q.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_count", 32'(drop_count), 32'(m_drop));
      chk("latest_data", 32'(latest_data), (int'(latest_sel) < N) ? 32'(m_lat[latest_sel]) : 32'd0);
      if (q.size() != 0) begin
        hf = q[0];
        chk("out_data", 32'(out_data), 32'(hf[m_rd * 16 +: 16]));
        chk("out_axis", 32'(out_axis), 32'(m_rd));
        chk("out_last", 32'(out_last), 32'(m_rd == N - 1));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    cyc();
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] tag);
    for (int a = 0; a < N; a++) begin
      send(8'(8'h40 + a));
      send(tag);
    end
  endtask

  int pr;

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; byte_valid = 1'b0; byte_data = '0;
    out_ready = 1'b0; ovf_clr = 1'b0; latest_sel = '0;
    cyc(); cyc();
    chk_en = 1'b1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_axis", 32'(out_axis), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Basic frame assembly and read-out
    send(8'h34); send(8'h12); send(8'hCD); send(8'hAB); send(8'h01); send(8'h00);
    chk("t1_count", 32'(frame_count), 32'd1);
    chk("t1_w0", 32'({out_valid, out_axis, out_data}), {13'd0, 1'b1, 2'd0, 16'h1234});
    out_ready = 1'b1;
    cyc(); chk("t1_w1", 32'({out_axis, out_last, out_data}), {13'd0, 2'd1, 1'b0, 16'hABCD});
    cyc(); chk("t1_w2", 32'({out_axis, out_last, out_data}), {13'd0, 2'd2, 1'b1, 16'h0001});
    cyc(); chk("t1_empty", 32'({out_valid, frame_count}), 32'd0);
    out_ready = 1'b0;

    // frame_start discards a partial frame
    send(8'h11); send(8'h22);
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); send(8'hEE); send(8'hFF);
    chk("t2_count", 32'(frame_count), 32'd1);
    chk("t2_w0", 32'(out_data), 32'h0000BBAA);
    out_ready = 1'b1;
    cyc(); chk("t2_w1", 32'(out_data), 32'h0000DDCC);
    cyc(); chk("t2_w2", 32'({out_last, out_data}), 32'h0001FFEE);
    cyc(); chk("t2_count0", 32'(frame_count), 32'd0);
    chk("t2_drop", 32'(drop_count), 32'd0);
    out_ready = 1'b0;

    // Overflow with DEPTH+2 frames
    for (int i = 0; i < D + 2; i++) send_frame(8'(i + 1));
    chk("t3_count", 32'(frame_count), 32'(D));
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_drop", 32'(drop_count), 32'd2);
    chk("t3_head", 32'(out_data), DROP_OLD ? 32'h0340 : 32'h0140);

    // Commit coinciding with last-word accept while full
    send(8'h40); send(8'h77); send(8'h41); send(8'h77); send(8'h42);
    out_ready = 1'b1;
    cyc(); cyc();
    byte_valid = 1'b1; byte_data = 8'h77;
    cyc();
    byte_valid = 1'b0; out_ready = 1'b0;
    chk("t4_count", 32'(frame_count), 32'(D));
    chk("t4_drop", 32'(drop_count), 32'd2);
    chk("t4_head", 32'(out_data), DROP_OLD ? 32'h0440 : 32'h0240);

    // Latest-sample tap and overflow clear
    latest_sel = 2'd1;
    frame_start = 1'b1; send(8'h00); frame_start = 1'b0;
    send(8'h00); send(8'h80);
    chk("t6_latest_pre", 32'(latest_data), 32'h7741);
    send(8'hFF);
    chk("t6_latest", 32'(latest_data), 32'hFF80);
    latest_sel = 2'd3; #1;
    chk("t6_latest_sel3", 32'(latest_data), 32'd0);
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
    chk("t6_ovf_clr", 32'(overflow), 32'd0);
    chk("t6_drop_clr", 32'(drop_count), 32'd0);

    // Reset mid-read discards everything
    out_ready = 1'b1; cyc();
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("rst_mid_count", 32'(frame_count), 32'd0);
    out_ready = 1'b0;

    // Randomized traffic
    pr = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) pr = int'($urandom_range(0, 3));
      byte_valid  = ($urandom_range(0, 3) != 0);
      byte_data   = 8'($urandom);
      frame_start = ($urandom_range(0, 49) == 0);
      out_ready   = (pr == 0) ? 1'b0 : (pr == 3) ? 1'b1 : ($urandom_range(0, pr) != 0);
      ovf_clr     = ($urandom_range(0, 199) == 0);
      latest_sel  = 2'($urandom);
      rst_n       = (c != 2000);
      cyc();
    end
    rst_n = 1'b1; byte_valid = 1'b0; frame_start = 1'b0; ovf_clr = 1'b0;

    // Drain, then a 3-frame burst with random stalls
    out_ready = 1'b1;
    for (int c = 0; c < 60; c++) cyc();
    for (int f = 0; f < 3; f++)
      for (int b = 0; b < 2 * N; b++) begin
        out_ready = ($urandom_range(0, 1) != 0);
        send(8'($urandom));
      end
    for (int c = 0; c < 40; c++) begin
      out_ready = ($urandom_range(0, 1) != 0);
      cyc();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
